// File: rtl/filter_seq_pkg.sv
// Purpose: shared FSM state encoding and power-on filter configuration for the sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package filter_seq_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    APPLY  = 2'd3
  } seq_state_t;

  // Configuration the filter runs with out of reset.
  localparam logic [7:0]  DEF_LAG       = 8'd32;
  localparam logic [15:0] DEF_THRESHOLD = 16'd256;   // 1.0 in Q8.8
  localparam logic [7:0]  DEF_INFLUENCE = 8'd64;     // 0.5 in Q1.7

endpackage

// File: rtl/sat_counter16.sv
// Purpose: 16-bit event counter that sticks at 0xFFFF; clear wins over increment.
// Latency: count reflects an increment or clear one clock after it is presented.
// Backpressure: none; every increment is either counted or absorbed by saturation.
//
// Ports: clk/rst (sync, active-high), clr (sync clear), inc (count one event),
//        count (current value).
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/filter_config_sequencer.sv
// Purpose: sequences host config writes into an adaptive peak filter and masks peaks during warmup.
// Latency: samples and results pass through combinationally; a config write costs a 2-cycle stall.
// Backpressure: s_ready and cfg_wr_ready drop together during DRAIN/APPLY; results are never stalled.
//
// Ports: cfg_wr_* host config handshake; s_* sample handshake into the filter;
//        flt_* side drives/observes the filter; out_* is the qualified result;
//        cnt_clr/peak_count count qualified peaks; busy is high outside RUN.
module filter_config_sequencer
  import filter_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int WARMUP_SAMPLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr_valid,
  output logic                    cfg_wr_ready,
  input  logic [7:0]              cfg_wr_lag,
  input  logic [15:0]             cfg_wr_threshold,
  input  logic [7:0]              cfg_wr_influence,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_sample,
  output logic                    flt_begin_config,
  output logic [7:0]              flt_cfg_lag,
  output logic [15:0]             flt_cfg_threshold,
  output logic [7:0]              flt_cfg_influence,
  output logic                    flt_valid_in,
  output logic [DATA_WIDTH-1:0]   flt_sample_in,
  input  logic                    flt_valid_out,
  input  logic                    flt_peak_out,
  input  logic [DATA_WIDTH-1:0]   flt_filtered_out,
  input  logic [2*DATA_WIDTH-1:0] flt_variance_out,
  output logic                    out_valid,
  output logic                    out_peak,
  output logic [DATA_WIDTH-1:0]   out_filtered,
  output logic [2*DATA_WIDTH-1:0] out_variance,
  input  logic                    cnt_clr,
  output logic [15:0]             peak_count,
  output logic                    busy
);

  localparam int WCW = $clog2(WARMUP_SAMPLES + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_SAMPLES - 1);

  seq_state_t     state, state_nxt;
  logic           pending;
  logic [WCW-1:0] warm_cnt;
  logic           tag;
  logic [7:0]     lag_stg;
  logic [15:0]    thr_stg;
  logic [7:0]     inf_stg;

  logic           acc_open;
  logic           cfg_acc;
  logic           s_acc;

  // Both handshakes share one gate so a config can never overtake a sample.
  assign acc_open     = ((state == WARMUP) || (state == RUN)) && !pending;
  assign cfg_wr_ready = acc_open;
  assign s_ready      = acc_open;
  assign cfg_acc      = cfg_wr_valid && acc_open;
  assign s_acc        = s_valid && acc_open;

  assign flt_valid_in  = s_acc;
  assign flt_sample_in = s_sample;

  assign flt_cfg_lag       = lag_stg;
  assign flt_cfg_threshold = thr_stg;
  assign flt_cfg_influence = inf_stg;

  assign busy = (state != RUN);

  // The filter answers one cycle after a sample; tag travels alongside it.
  assign out_valid    = flt_valid_out;
  assign out_filtered = flt_filtered_out;
  assign out_variance = flt_variance_out;
  assign out_peak     = flt_peak_out && flt_valid_out && tag;

  always_comb begin
    state_nxt        = state;
    flt_begin_config = 1'b0;
    case (state)
      WARMUP: begin
        // A config write abandons the warmup even if this sample would finish it.
        if (cfg_acc) begin
          state_nxt = DRAIN;
        end else if (s_acc && (warm_cnt == WARM_LAST)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cfg_acc) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Lets the result of the last old-config sample come back first.
        state_nxt = APPLY;
      end
      APPLY: begin
        flt_begin_config = 1'b1;
        state_nxt        = WARMUP;
      end
      default: begin
        state_nxt = WARMUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARMUP;
      pending  <= 1'b0;
      warm_cnt <= '0;
      tag      <= 1'b0;
      lag_stg  <= DEF_LAG;
      thr_stg  <= DEF_THRESHOLD;
      inf_stg  <= DEF_INFLUENCE;
    end else begin
      state <= state_nxt;
      tag   <= s_acc && (state == RUN);

      if (cfg_acc) begin
        lag_stg <= cfg_wr_lag;
        thr_stg <= cfg_wr_threshold;
        inf_stg <= cfg_wr_influence;
        pending <= 1'b1;
      end

      if (state == APPLY) begin
        pending  <= 1'b0;
        warm_cnt <= '0;
      end else if ((state == WARMUP) && s_acc && !cfg_acc) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  sat_counter16 u_peak_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (out_peak),
    .count (peak_count)
  );

endmodule

// File: tb/tb_filter_config_sequencer.sv
// Purpose: random and directed check of filter_config_sequencer against a counting reference model.
// Latency: inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Backpressure: the bench plays the filter, returning each accepted sample's result one cycle later.
module tb_filter_config_sequencer;

  localparam int DW = 16;
  localparam int WS = 256;

  logic          clk;
  logic          rst;
  logic          cfg_wr_valid;
  logic          cfg_wr_ready;
  logic [7:0]    cfg_wr_lag;
  logic [15:0]   cfg_wr_threshold;
  logic [7:0]    cfg_wr_influence;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_sample;
  logic          flt_begin_config;
  logic [7:0]    flt_cfg_lag;
  logic [15:0]   flt_cfg_threshold;
  logic [7:0]    flt_cfg_influence;
  logic          flt_valid_in;
  logic [DW-1:0] flt_sample_in;
  logic          flt_valid_out;
  logic          flt_peak_out;
  logic [DW-1:0] flt_filtered_out;
  logic [2*DW-1:0] flt_variance_out;
  logic          out_valid;
  logic          out_peak;
  logic [DW-1:0] out_filtered;
  logic [2*DW-1:0] out_variance;
  logic          cnt_clr;
  logic [15:0]   peak_count;
  logic          busy;

  filter_config_sequencer #(.DATA_WIDTH(DW), .WARMUP_SAMPLES(WS)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_wr_valid      (cfg_wr_valid),
    .cfg_wr_ready      (cfg_wr_ready),
    .cfg_wr_lag        (cfg_wr_lag),
    .cfg_wr_threshold  (cfg_wr_threshold),
    .cfg_wr_influence  (cfg_wr_influence),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_sample          (s_sample),
    .flt_begin_config  (flt_begin_config),
    .flt_cfg_lag       (flt_cfg_lag),
    .flt_cfg_threshold (flt_cfg_threshold),
    .flt_cfg_influence (flt_cfg_influence),
    .flt_valid_in      (flt_valid_in),
    .flt_sample_in     (flt_sample_in),
    .flt_valid_out     (flt_valid_out),
    .flt_peak_out      (flt_peak_out),
    .flt_filtered_out  (flt_filtered_out),
    .flt_variance_out  (flt_variance_out),
    .out_valid         (out_valid),
    .out_peak          (out_peak),
    .out_filtered      (out_filtered),
    .out_variance      (out_variance),
    .cnt_clr           (cnt_clr),
    .peak_count        (peak_count),
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: stall cycles left (2 = draining, 1 = applying),
  // accepted samples still needed before peaks count, current filter config,
  // and the result the emulated filter presents this cycle.
  int          m_stall;
  int          m_warm_left;
  logic [7:0]  m_lag;
  logic [15:0] m_thr;
  logic [7:0]  m_inf;
  logic [15:0] m_cnt;
  bit          f_vld, f_pk, f_tag;
  logic [DW-1:0]   f_flt;
  logic [2*DW-1:0] f_var;
  bit          full_chk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_spike(input logic [DW-1:0] smp);
    return $signed(smp) > 1000;
  endfunction

  // One clock: present the filter result, compare mid-cycle, then advance the model.
  task automatic step();
    bit exp_open, exp_pk, acc, cacc;
    flt_valid_out    = f_vld;
    flt_peak_out     = f_pk;
    flt_filtered_out = f_flt;
    flt_variance_out = f_var;
    exp_open = (m_stall == 0);
    exp_pk   = f_vld && f_pk && f_tag;
    #4;
    if (full_chk) begin
      check_eq("s_ready",      s_ready,           exp_open);
      check_eq("cfg_wr_ready", cfg_wr_ready,      exp_open);
      check_eq("flt_valid_in", flt_valid_in,      s_valid && exp_open);
      check_eq("flt_sample",   flt_sample_in,     s_sample);
      check_eq("begin_config", flt_begin_config,  m_stall == 1);
      check_eq("busy",         busy,              !(m_stall == 0 && m_warm_left == 0));
      check_eq("cfg_lag",      flt_cfg_lag,       m_lag);
      check_eq("cfg_thr",      flt_cfg_threshold, m_thr);
      check_eq("cfg_inf",      flt_cfg_influence, m_inf);
      check_eq("out_valid",    out_valid,         f_vld);
      check_eq("out_peak",     out_peak,          exp_pk);
      check_eq("out_filtered", out_filtered,      f_flt);
      check_eq("out_variance", out_variance,      f_var);
      check_eq("peak_count",   peak_count,        m_cnt);
    end
    @(posedge clk);
    acc  = s_valid && exp_open;
    cacc = cfg_wr_valid && exp_open;
    f_tag = acc && (m_warm_left == 0);
    f_vld = acc;
    f_pk  = acc ? is_spike(s_sample) : 1'($urandom_range(0, 1));
    f_flt = s_sample ^ 16'h00FF;
    f_var = {s_sample, ~s_sample};
    if (cnt_clr) m_cnt = 16'd0;
    else if (exp_pk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_stall == 2) begin
      m_stall = 1;
    end else if (m_stall == 1) begin
      m_stall     = 0;
      m_warm_left = WS;
    end else if (cacc) begin
      m_stall = 2;
      m_lag   = cfg_wr_lag;
      m_thr   = cfg_wr_threshold;
      m_inf   = cfg_wr_influence;
    end else if (acc && m_warm_left > 0) begin
      m_warm_left--;
    end
    #1;
  endtask

  task automatic cyc(input bit sv, input logic [DW-1:0] smp, input bit cv,
                     input logic [7:0] lg, input logic [15:0] th, input logic [7:0] inf,
                     input bit clr);
    s_valid          = sv;
    s_sample         = smp;
    cfg_wr_valid     = cv;
    cfg_wr_lag       = lg;
    cfg_wr_threshold = th;
    cfg_wr_influence = inf;
    cnt_clr          = clr;
    step();
  endtask

  task automatic samp(input logic [DW-1:0] smp);
    cyc(1'b1, smp, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_sample = '0; cfg_wr_valid = 1'b0;
    cfg_wr_lag = '0; cfg_wr_threshold = '0; cfg_wr_influence = '0; cnt_clr = 1'b0;
    flt_valid_out = 1'b0; flt_peak_out = 1'b0; flt_filtered_out = '0; flt_variance_out = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_stall = 0; m_warm_left = WS;
    m_lag = 8'd32; m_thr = 16'd256; m_inf = 8'd64; m_cnt = 16'd0;
    f_vld = 1'b0; f_pk = 1'b0; f_tag = 1'b0; f_flt = '0; f_var = '0;
  endtask

  initial begin
    logic [DW-1:0] rs;
    full_chk = 1'b1;
    do_reset();
    check_eq("rst_s_ready", s_ready, 1'b1);
    check_eq("rst_cfg_rdy", cfg_wr_ready, 1'b1);
    check_eq("rst_busy",    busy, 1'b1);
    check_eq("rst_lag",     flt_cfg_lag, 8'd32);
    check_eq("rst_thr",     flt_cfg_threshold, 16'd256);
    check_eq("rst_inf",     flt_cfg_influence, 8'd64);

    // Warmup with a spike that must stay masked.
    for (int i = 0; i < WS; i++) samp((i == 100) ? 16'd5000 : 16'd10);
    check_eq("warm_busy_done", busy, 1'b0);
    check_eq("warm_pcnt",      peak_count, 16'd0);

    // Unmasked spike in RUN.
    samp(16'd10); samp(16'd5000); samp(16'd10);
    cyc(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    check_eq("run_pcnt", peak_count, 16'd1);

    // Config write in RUN: two stall cycles, strobe in the second.
    cyc(1'b0, 16'd10, 1'b1, 8'd16, 16'd512, 8'd32, 1'b0);
    check_eq("drain_srdy",  s_ready, 1'b0);
    check_eq("drain_begin", flt_begin_config, 1'b0);
    cyc(1'b1, 16'd10, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    check_eq("apply_srdy",  s_ready, 1'b0);
    check_eq("apply_begin", flt_begin_config, 1'b1);
    cyc(1'b1, 16'd10, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    check_eq("post_srdy", s_ready, 1'b1);
    check_eq("new_lag",   flt_cfg_lag, 8'd16);
    check_eq("new_thr",   flt_cfg_threshold, 16'd512);
    check_eq("new_inf",   flt_cfg_influence, 8'd32);
    for (int i = 0; i < WS - 1; i++) samp(16'd10);
    check_eq("rewarm_busy", busy, 1'b1);
    samp(16'd10);
    check_eq("rewarm_done", busy, 1'b0);

    // Config and a RUN spike in the same cycle: result is counted during DRAIN.
    cyc(1'b1, 16'd5000, 1'b1, 8'd8, 16'd300, 8'd16, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    check_eq("same_cyc_pcnt", peak_count, 16'd2);
    check_eq("same_cyc_lag",  flt_cfg_lag, 8'd8);

    // Config during warmup after 100 samples restarts the full warmup.
    for (int i = 0; i < 100; i++) samp(16'd10);
    cyc(1'b1, 16'd10, 1'b1, 8'd20, 16'd400, 8'd100, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    for (int i = 0; i < WS - 1; i++) samp((i == 50) ? 16'd5000 : 16'd10);
    check_eq("abandon_busy", busy, 1'b1);
    samp(16'd10);
    check_eq("abandon_done", busy, 1'b0);
    check_eq("abandon_pcnt", peak_count, 16'd2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0:       rs = 16'd5000;
        1:       rs = 16'hF448;   // -3000, large but not a peak
        default: rs = 16'($urandom_range(0, 40));
      endcase
      cyc(($urandom_range(0, 3) != 0), rs, ($urandom_range(0, 39) == 0),
          8'($urandom), 16'($urandom), 8'($urandom), ($urandom_range(0, 49) == 0));
    end

    // Saturate the peak counter, then clear while a peak is present.
    do_reset();
    for (int i = 0; i < WS; i++) samp(16'd10);
    full_chk = 1'b0;
    for (int i = 0; i < 65540; i++) samp(16'd5000);
    full_chk = 1'b1;
    check_eq("sat_max", peak_count, 16'hFFFF);
    samp(16'd5000);
    check_eq("sat_hold", peak_count, 16'hFFFF);
    cyc(1'b1, 16'd5000, 1'b0, 8'd0, 16'd0, 8'd0, 1'b1);
    check_eq("clr_priority", peak_count, 16'd0);
    cyc(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0);
    check_eq("count_after_clr", peak_count, 16'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/filter_config_sequencer.md
FILTER_CONFIG_SEQUENCER -- requirements
Module: filter_config_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width, matching the adaptive filter.
REQ-002 SHALL have parameter WARMUP_SAMPLES, default 256: accepted samples whose peaks are masked after any (re)configuration.
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_wr_valid / cfg_wr_ready  in/out  1/1  host config handshake.
- cfg_wr_lag  in  8  staged lag.
- cfg_wr_threshold  in  16  Q8.8.
- cfg_wr_influence  in  8  Q1.7.
- s_valid / s_ready  in/out  1/1  sample handshake.
- s_sample  in  DATA_WIDTH  signed sample.
- flt_begin_config  out  1  config strobe to filter.
- flt_cfg_lag  out  8  config to filter.
- flt_cfg_threshold  out  16  config to filter.
- flt_cfg_influence  out  8  config to filter.
- flt_valid_in  out  1  sample strobe to filter.
- flt_sample_in  out  DATA_WIDTH  sample to filter.
- flt_valid_out / flt_peak_out  in  1/1  filter result.
- flt_filtered_out  in  DATA_WIDTH  filter mean.
- flt_variance_out  in  2*DATA_WIDTH  filter variance.
- out_valid / out_peak  out  1/1  qualified result.
- out_filtered  out  DATA_WIDTH  qualified mean.
- out_variance  out  2*DATA_WIDTH  qualified variance.
- cnt_clr  in  1  clears peak_count.
- peak_count  out  16  saturating count of qualified peaks.
- busy  out  1  high when state is not RUN.

Function
REQ-004 SHALL implement FSM states WARMUP, RUN, DRAIN and APPLY; the reset state is WARMUP.
REQ-005 SHALL drive cfg_wr_ready = (state in {WARMUP, RUN}) && !pending.
- On cfg_wr_valid && cfg_wr_ready: load lag, threshold and influence into staging registers; set pending; next state DRAIN.
REQ-006 SHALL drive s_ready = (state in {WARMUP, RUN}) && !pending.
REQ-007 SHALL drive flt_valid_in = s_valid && s_ready and flt_sample_in = s_sample combinationally (zero latency).
REQ-008 SHALL hold flt_cfg_* equal to the staging registers at all times; zero values pass through unmodified.
REQ-009 SHALL spend exactly one cycle in DRAIN, which absorbs the one-cycle filter result latency, then go to APPLY.
REQ-010 SHALL, in APPLY, assert flt_begin_config for exactly one cycle with flt_valid_in = 0; clear pending; clear the warmup counter; next state WARMUP.
REQ-011 SHALL, in WARMUP, count accepted samples. When the WARMUP_SAMPLES-th sample is accepted, the next state is RUN and the counter stops.
REQ-012 SHALL register a tag with each accepted sample, tag = (state == RUN) at accept time; the tag applies to the filter result one cycle later.
REQ-013 SHALL drive the output signals combinationally as follows:
- out_valid = flt_valid_out.
- out_filtered and out_variance pass through from the filter.
- out_peak = flt_peak_out && flt_valid_out && tag.
REQ-014 SHALL increment peak_count on each out_peak, saturating at 0xFFFF. cnt_clr has priority, giving 0 even when out_peak is high in the same cycle.
REQ-015 SHALL, when a config handshake and a sample handshake occur in the same cycle, process the sample under the old configuration and deliver its result normally during DRAIN.
REQ-016 SHALL, when a config handshake occurs in WARMUP, abandon the partial warmup; the count restarts from 0 after APPLY.
REQ-017 SHALL cause a total configuration stall of exactly 2 cycles with s_ready low (DRAIN, APPLY) per accepted config write.

Reset
REQ-018 SHALL, on rst, set the following, discarding any staged config:
- state WARMUP, pending 0, warmup counter 0, tag 0, peak_count 0.
- flt_cfg_lag 32, flt_cfg_threshold 256, flt_cfg_influence 64.
- flt_begin_config 0.
REQ-019 SHALL give, in the first cycle after reset: s_ready 1, cfg_wr_ready 1, busy 1, out_peak 0.

Structure
REQ-020 SHALL place the FSM state enum and the default constants (32, 256, 64) in shared package filter_seq_pkg.
REQ-021 SHALL contain a single sub-module sat_counter16 (clear, increment, saturating) for peak_count; all other logic is flat.

Verification
REQ-022 SHALL cover the following directed scenarios:
- Reset, then feed 256 samples with one spike of +5000 at sample 100 -> out_peak stays 0; busy falls after the 256th accept; peak_count 0.
- In RUN, feed a baseline of 10 with a spike of +5000 -> out_peak 1 exactly one cycle after the spike's flt_valid_in; peak_count 1.
- Config write (lag 16, threshold 512, influence 32) in RUN -> s_ready low for 2 cycles; flt_begin_config pulses once in the 2nd of those cycles; flt_cfg_* = 16/512/32; busy 1 for 256 accepted samples.
- Config write and sample accepted in the same cycle -> the sample's result appears during DRAIN with tag = RUN; the config still applies.
- Config write during WARMUP after 100 samples -> a fresh 256-sample warmup follows APPLY.
- Saturate peak_count at 0xFFFF, then assert cnt_clr together with out_peak -> peak_count 0.
